// File: rtl/scope_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_bus_pkg
// Purpose  : Shared definitions for the scope MCU parallel bus: command
//            codes, master state encoding and transaction size limit.
// Revision : 1.0 - initial release
// ============================================================================
package scope_bus_pkg;

    // Longest data phase of one transaction; the responder's data index is
    // two bits wide, so it wraps after four bytes.
    localparam int MAX_BYTES = 4;

    // Responder command codes
    localparam logic [7:0] CMD_RESET      = 8'h01;
    localparam logic [7:0] CMD_READY      = 8'h05;
    localparam logic [7:0] CMD_IDENT      = 8'h06;
    localparam logic [7:0] CMD_RATE       = 8'h0D;
    localparam logic [7:0] CMD_DEBUG      = 8'h0E;
    localparam logic [7:0] CMD_TRIG_CHAN  = 8'h15;
    localparam logic [7:0] CMD_TRIG_EDGE  = 8'h16;
    localparam logic [7:0] CMD_TRIG_LEVEL = 8'h17;
    localparam logic [7:0] CMD_TRIG_MODE  = 8'h1A;
    localparam logic [7:0] CMD_BUF1       = 8'h20;
    localparam logic [7:0] CMD_BUF2       = 8'h22;
    localparam logic [7:0] CMD_OFS1       = 8'h32;
    localparam logic [7:0] CMD_RLY1       = 8'h33;
    localparam logic [7:0] CMD_ACDC1      = 8'h34;
    localparam logic [7:0] CMD_OFS2       = 8'h35;
    localparam logic [7:0] CMD_RLY2       = 8'h36;
    localparam logic [7:0] CMD_ACDC2      = 8'h37;
    localparam logic [7:0] CMD_DISPLAY    = 8'h38;

    // Bus master sequencer states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CMD_SETUP = 4'd1,
        ST_CMD_LOW   = 4'd2,
        ST_CMD_HIGH  = 4'd3,
        ST_TURN      = 4'd4,
        ST_DAT_SETUP = 4'd5,
        ST_DAT_LOW   = 4'd6,
        ST_DAT_HIGH  = 4'd7,
        ST_DONE      = 4'd8
    } mcu_state_t;

endpackage
`default_nettype wire

// File: rtl/mcu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mcu_bus_master
// Purpose  : Initiator of the scope MCU parallel bus. Issues one command
//            byte followed by 0..4 data bytes (write or read) with
//            programmable setup / strobe-low / hold timing.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_bus_master
    import scope_bus_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int LOW_CYC   = 4,
    parameter int HIGH_CYC  = 2
) (
    input  logic        i_xtal,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_cmd,
    input  logic        i_write,
    input  logic [2:0]  i_len,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mcu_clk,
    output logic        o_mcu_rws,
    output logic        o_mcu_dcs,
    output logic [7:0]  o_mcu_d,
    output logic        o_mcu_d_oe,
    input  logic [7:0]  i_mcu_d
);

    // Last phase-counter value of each timed phase
    localparam logic [7:0] c_setup_last = 8'(SETUP_CYC - 1);
    localparam logic [7:0] c_low_last   = 8'(LOW_CYC - 1);
    localparam logic [7:0] c_high_last  = 8'(HIGH_CYC - 1);
    localparam logic [2:0] c_max_len    = 3'(MAX_BYTES);

    mcu_state_t  r_state;
    mcu_state_t  w_next;
    logic [7:0]  r_phase;
    logic [2:0]  r_byte;
    logic [2:0]  r_len;
    logic [7:0]  r_cmd;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  w_len_clamped;

    assign w_len_clamped = (i_len > c_max_len) ? c_max_len : i_len;
    assign o_rdata       = r_rdata;

    // State register and phase counter; the counter restarts on every state change
    always_ff @(posedge i_xtal) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_phase <= 8'd0;
        end else begin
            r_state <= w_next;
            r_phase <= (w_next != r_state) ? 8'd0 : r_phase + 8'd1;
        end
    end

    // Transaction latches, byte counter, write shifter and read capture
    always_ff @(posedge i_xtal) begin
        if (i_reset) begin
            r_byte  <= 3'd0;
            r_len   <= 3'd0;
            r_cmd   <= 8'd0;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_byte  <= 3'd0;
                r_len   <= w_len_clamped;
                r_cmd   <= i_cmd;
                r_write <= i_write;
                r_wdata <= i_wdata;
                r_rdata <= 32'd0;
            end
            // Responder data has had the whole low phase to settle
            if (r_state == ST_DAT_LOW && !r_write && r_phase == c_low_last) begin
                case (r_byte[1:0])
                    2'd0:    r_rdata[31:24] <= i_mcu_d;
                    2'd1:    r_rdata[23:16] <= i_mcu_d;
                    2'd2:    r_rdata[15:8]  <= i_mcu_d;
                    default: r_rdata[7:0]   <= i_mcu_d;
                endcase
            end
            // Next write byte always sits in the top lane of the shifter
            if (r_state == ST_DAT_HIGH && r_phase == c_high_last) begin
                r_byte  <= r_byte + 3'd1;
                r_wdata <= {r_wdata[23:0], 8'h00};
            end
        end
    end

    // Next-state decode and bus line drive
    always_comb begin
        w_next     = r_state;
        o_mcu_clk  = 1'b1;
        o_mcu_rws  = 1'b1;
        o_mcu_dcs  = 1'b1;
        o_mcu_d    = 8'h00;
        o_mcu_d_oe = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = ST_CMD_SETUP;
            end
            ST_CMD_SETUP: begin
                o_mcu_d    = r_cmd;
                o_mcu_d_oe = 1'b1;
                if (r_phase == c_setup_last) w_next = ST_CMD_LOW;
            end
            ST_CMD_LOW: begin
                o_mcu_clk  = 1'b0;
                o_mcu_d    = r_cmd;
                o_mcu_d_oe = 1'b1;
                if (r_phase == c_low_last) w_next = ST_CMD_HIGH;
            end
            ST_CMD_HIGH: begin
                o_mcu_d    = r_cmd;
                o_mcu_d_oe = 1'b1;
                if (r_phase == c_high_last) begin
                    if (r_len == 3'd0) w_next = ST_DONE;
                    else if (r_write)  w_next = ST_DAT_SETUP;
                    else               w_next = ST_TURN;
                end
            end
            ST_TURN: begin
                // Bus released with rws still high before the responder drives
                w_next = ST_DAT_SETUP;
            end
            ST_DAT_SETUP, ST_DAT_LOW, ST_DAT_HIGH: begin
                o_mcu_dcs  = 1'b0;
                o_mcu_rws  = r_write;
                o_mcu_d_oe = r_write;
                o_mcu_d    = r_write ? r_wdata[31:24] : 8'h00;
                if (r_state == ST_DAT_SETUP) begin
                    if (r_phase == c_setup_last) w_next = ST_DAT_LOW;
                end else if (r_state == ST_DAT_LOW) begin
                    o_mcu_clk = 1'b0;
                    if (r_phase == c_low_last) w_next = ST_DAT_HIGH;
                end else if (r_phase == c_high_last) begin
                    w_next = (r_byte == r_len - 3'd1) ? ST_DONE : ST_DAT_SETUP;
                end
            end
            ST_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_bus_master
// Purpose  : Self-checking bench for mcu_bus_master with a responder model
//            and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_bus_master;
    import scope_bus_pkg::*;

    localparam int SETUP = 2;
    localparam int LOW   = 4;
    localparam int HIGH  = 2;
    localparam int P     = SETUP + LOW + HIGH;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cmd;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy, done;
    logic        mcu_clk, mcu_rws, mcu_dcs, mcu_oe;
    logic [7:0]  mcu_dout, mcu_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mcu_bus_master #(.SETUP_CYC(SETUP), .LOW_CYC(LOW), .HIGH_CYC(HIGH)) dut (
        .i_xtal(clk), .i_reset(rst), .i_start(start), .i_cmd(cmd),
        .i_write(wr), .i_len(len), .i_wdata(wdata), .o_rdata(rdata),
        .o_busy(busy), .o_done(done), .o_mcu_clk(mcu_clk),
        .o_mcu_rws(mcu_rws), .o_mcu_dcs(mcu_dcs), .o_mcu_d(mcu_dout),
        .o_mcu_d_oe(mcu_oe), .i_mcu_d(mcu_din)
    );

    // Responder: index cleared by a command strobe, advanced on each rising data strobe
    logic [7:0] resp_mem [4];
    logic [1:0] resp_idx = 2'd0;
    logic [7:0] resp_wr_q [$];
    logic       resp_drv;

    assign resp_drv = !mcu_rws && !mcu_dcs;
    assign mcu_din  = mcu_oe ? mcu_dout : (resp_drv ? resp_mem[resp_idx] : 8'hFF);

    always @(mcu_clk) begin
        if (!mcu_clk) begin
            if (mcu_dcs) resp_idx <= 2'd0;
        end else if (!mcu_dcs) begin
            if (mcu_rws) resp_wr_q.push_back(mcu_dout);
            resp_idx <= resp_idx + 2'd1;
        end
    end

    typedef struct packed {
        logic       c, rws, dcs, oe, bsy, dn;
        logic [7:0] d;
    } smp_t;
    smp_t s_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction, then compare the observed bus against the rules
    task automatic run_txn(input logic [7:0] t_cmd, input logic t_wr, input logic [2:0] t_len,
                           input logic [31:0] t_wdata, input logic [31:0] t_rmem,
                           input int extra_at, output logic [31:0] cap);
        int len_c, done_cyc, bad, bad_busy, lo, hi;
        int falls [$];
        int rises [$];
        logic [31:0] exp_rd, exp_cap;
        logic [7:0]  ed;
        len_c = (t_len > 3'd4) ? 4 : int'(t_len);
        for (int k = 0; k < 4; k++) resp_mem[k] = t_rmem[31 - 8*k -: 8];
        resp_wr_q.delete();
        s_q.delete();
        @(negedge clk);
        start = 1'b1; cmd = t_cmd; wr = t_wr; len = t_len; wdata = t_wdata;
        @(posedge clk);
        #1;
        start = 1'b0; cmd = 8'($urandom); wr = 1'($urandom);
        len = 3'($urandom); wdata = $urandom;
        done_cyc = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            s_q.push_back({mcu_clk, mcu_rws, mcu_dcs, mcu_oe, busy, done, mcu_dout});
            if (done) begin
                done_cyc = n;
                break;
            end
            start = (n == extra_at);
        end
        start = 1'b0;
        check_eq("done_cycle", done_cyc, 1 + (1 + len_c) * P + ((!t_wr && len_c > 0) ? 1 : 0));
        check_eq("rdata", rdata, exp_rd_f(t_wr, len_c, t_rmem));

        for (int i = 0; i < s_q.size(); i++) begin
            if (!s_q[i].c && (i == 0 || s_q[i-1].c)) falls.push_back(i);
            if (s_q[i].c && i > 0 && !s_q[i-1].c) rises.push_back(i);
        end
        check_eq("strobe_count", falls.size(), 1 + len_c);
        bad = 0;
        for (int j = 0; j < falls.size() && j < rises.size() && j <= len_c; j++) begin
            if (j == 0)     ed = t_cmd;
            else if (t_wr)  ed = t_wdata[31 - 8*(j-1) -: 8];
            else            ed = 8'h00;
            check_eq("strobe_lines",
                     {s_q[falls[j]].dcs, s_q[falls[j]].rws, s_q[falls[j]].oe,
                      s_q[falls[j]].oe ? s_q[falls[j]].d : 8'h00},
                     {(j == 0), (j == 0) ? 1'b1 : t_wr, (j == 0) ? 1'b1 : t_wr, ed});
            check_eq("low_width", rises[j] - falls[j], LOW);
            lo = (falls[j] - SETUP < 0) ? 0 : falls[j] - SETUP;
            hi = (rises[j] + HIGH - 1 > s_q.size() - 1) ? s_q.size() - 1 : rises[j] + HIGH - 1;
            for (int i = lo; i <= hi; i++)
                if ({s_q[i].rws, s_q[i].dcs, s_q[i].oe} != {s_q[falls[j]].rws, s_q[falls[j]].dcs, s_q[falls[j]].oe}
                    || (s_q[i].oe && s_q[i].d != s_q[falls[j]].d)) bad++;
        end
        bad_busy = 0;
        for (int i = 0; i < s_q.size(); i++) begin
            if (s_q[i].oe && !s_q[i].rws && !s_q[i].dcs) bad++;
            if (i > 0 && !s_q[i].rws && s_q[i-1].rws && s_q[i-1].oe) bad++;
            if (i < s_q.size() - 1 && (!s_q[i].bsy || s_q[i].dn)) bad_busy++;
        end
        check_eq("line_hold_and_turnaround", bad, 0);
        check_eq("busy_during_txn", bad_busy, 0);

        cap = 32'd0;
        for (int k = 0; k < resp_wr_q.size() && k < 4; k++) cap[31 - 8*k -: 8] = resp_wr_q[k];
        exp_cap = 32'd0;
        if (t_wr) for (int k = 0; k < len_c; k++) exp_cap[31 - 8*k -: 8] = t_wdata[31 - 8*k -: 8];
        check_eq("responder_writes", {resp_wr_q.size(), cap}, {(t_wr ? len_c : 0), exp_cap});

        @(negedge clk);
        check_eq("idle_after_done", {busy, done}, 2'b00);
    endtask

    function automatic logic [31:0] exp_rd_f(input logic t_wr, input int n, input logic [31:0] mem);
        logic [31:0] r;
        r = 32'd0;
        if (!t_wr) for (int k = 0; k < n; k++) r[31 - 8*k -: 8] = mem[31 - 8*k -: 8];
        return r;
    endfunction

    logic [7:0]  cmds [18];
    logic [31:0] cap;
    int          found, dones;

    initial begin
        cmds = '{CMD_RESET, CMD_READY, CMD_IDENT, CMD_RATE, CMD_DEBUG, CMD_TRIG_CHAN,
                 CMD_TRIG_EDGE, CMD_TRIG_LEVEL, CMD_TRIG_MODE, CMD_BUF1, CMD_BUF2,
                 CMD_OFS1, CMD_RLY1, CMD_ACDC1, CMD_OFS2, CMD_RLY2, CMD_ACDC2, CMD_DISPLAY};
        rst = 1'b1; start = 1'b0; cmd = 8'h00; wr = 1'b0; len = 3'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_lines", {mcu_clk, mcu_rws, mcu_dcs, mcu_oe, busy, done}, 6'b111000);
        check_eq("reset_data", {mcu_dout, rdata}, 40'd0);

        run_txn(CMD_DISPLAY, 1'b1, 3'd1, 32'h8000_0000, 32'h0, 0, cap);
        run_txn(CMD_IDENT,   1'b0, 3'd2, 32'h0,         32'h1432_0000, 0, cap);
        run_txn(CMD_RATE,    1'b1, 3'd4, 32'h0001_2345, 32'h0, 0, cap);
        check_eq("rate_register", cap[23:0], 24'h012345);
        run_txn(CMD_RESET,   1'b0, 3'd0, 32'h0,         32'hDEAD_BEEF, 0, cap);
        run_txn(CMD_BUF1,    1'b1, 3'd7, 32'hA1B2_C3D4, 32'h0, 5, cap);
        run_txn(CMD_BUF2,    1'b0, 3'd6, 32'h0,         32'h5566_7788, 20, cap);

        for (int t = 0; t < 24; t++)
            run_txn(cmds[$urandom_range(0, 17)], 1'($urandom), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom_range(0, 30), cap);

        // Reset while a data strobe is low
        @(negedge clk);
        start = 1'b1; cmd = CMD_RATE; wr = 1'b1; len = 3'd4; wdata = 32'h1122_3344;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!mcu_clk && !mcu_dcs) begin
                found = 1;
                break;
            end
        end
        check_eq("reached_dat_low", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_reset_lines", {mcu_clk, mcu_rws, mcu_dcs, mcu_oe, busy, done}, 6'b111000);
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check_eq("no_done_after_reset", dones, 0);
        run_txn(CMD_OFS1, 1'b1, 3'd3, 32'h0BAD_F00D, 32'h0, 0, cap);
        run_txn(CMD_IDENT, 1'b0, 3'd4, 32'h0, 32'hCAFE_1234, 0, cap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
